// File: rtl/ecc_lockstep_chk.sv
// ecc_lockstep_chk
//   Two-stage SECDED check-and-correct stage with lockstep fault detection.
//   Every accepted beat is decoded by two independent copies of the SECDED
//   decoder. A disagreement is reported as a logic fault and the raw data is
//   forwarded. A one-shot self-test corrupts copy B's syndrome to prove the
//   comparator works.
//
//   Codeword layout: Hamming positions 1..DATA_WIDTH+PARITY_WIDTH-1. The check
//   bits parity[PARITY_WIDTH-2:0] sit at the power-of-two positions. Data bits
//   fill the remaining positions in ascending order, starting at position 3.
//   parity[PARITY_WIDTH-1] is the overall parity over data and Hamming check
//   bits.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_vld/in_rdy           input handshake
//   data_in, parity_in      stored data and check bits
//   bypass                  skip correction for this beat
//   ecc_fault_detc_en       enable the lockstep compare
//   inj_req                 arm a self-test on the next accepted beat
//   cnt_clr                 clear the counters and the irq
//   fault_thresh            irq threshold on fault_cnt (0 = irq disabled)
//   out_vld/out_rdy         output handshake
//   data_out                corrected data (raw data on fault or bypass)
//   sbit_err/dbit_err/ecc_fault  per-beat flags, qualified by out_vld
//   sbit_cnt/dbit_cnt/fault_cnt  saturating event counters
//   fault_irq               level irq, fault_cnt >= fault_thresh
module ecc_lockstep_chk #(
    parameter int DATA_WIDTH   = 94,
    parameter int PARITY_WIDTH = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [PARITY_WIDTH-1:0] parity_in,
    input  logic                    bypass,
    input  logic                    ecc_fault_detc_en,
    input  logic                    inj_req,
    input  logic                    cnt_clr,
    input  logic [CNT_WIDTH-1:0]    fault_thresh,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    sbit_err,
    output logic                    dbit_err,
    output logic                    ecc_fault,
    output logic [CNT_WIDTH-1:0]    sbit_cnt,
    output logic [CNT_WIDTH-1:0]    dbit_cnt,
    output logic [CNT_WIDTH-1:0]    fault_cnt,
    output logic                    fault_irq
);

    localparam int HW   = PARITY_WIDTH - 1;   // Hamming syndrome width
    localparam int NPOS = DATA_WIDTH + HW;    // highest valid codeword position

    typedef struct packed {
        logic [DATA_WIDTH-1:0] mask;
        logic                  sbit;
        logic                  dbit;
    } dec_t;

    // Codeword position of data bit idx: the idx-th non-power-of-two position.
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned cnt;
        int unsigned pos;
        cnt = 0;
        pos = 0;
        for (int unsigned p = 1; p < (32'd1 << HW); p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx && pos == 0) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    // One SECDED decoder copy. inj flips Hamming syndrome bit 0.
    function automatic dec_t secded_decode(
        input logic [DATA_WIDTH-1:0]   d,
        input logic [PARITY_WIDTH-1:0] p,
        input logic                    inj,
        input logic                    byp
    );
        dec_t        r;
        logic [HW-1:0] syn;
        logic        ovr;
        logic        in_rng;
        syn = p[HW-1:0];
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (d[i]) syn = syn ^ HW'(data_pos(i));
        end
        ovr    = ^{d, p};
        syn[0] = syn[0] ^ inj;
        // A syndrome pointing past the codeword cannot come from a single
        // flip, so it is treated as uncorrectable.
        in_rng = (32'(syn) <= 32'(NPOS));
        for (int i = 0; i < DATA_WIDTH; i++) begin
            r.mask[i] = ovr & in_rng & (syn == HW'(data_pos(i)));
        end
        r.sbit = ovr & in_rng;
        r.dbit = (ovr & ~in_rng) | (~ovr & (syn != '0));
        if (byp) r = '0;
        return r;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic                    vld_p1;
    logic [DATA_WIDTH-1:0]   data_p1;
    logic [PARITY_WIDTH-1:0] parity_p1;
    logic                    byp_p1;
    logic                    inj_p1;
    logic                    inj_armed;
    logic                    vld_p2;
    logic                    accept;
    logic                    load_p2;
    logic                    take_p2;
    dec_t                    dec_a;
    dec_t                    dec_b;
    logic                    fault_p1;
    logic [DATA_WIDTH-1:0]   corr_p1;

    assign load_p2 = ~vld_p2 | out_rdy;
    assign in_rdy  = ~vld_p1 | load_p2;
    assign accept  = in_vld & in_rdy;
    assign take_p2 = vld_p2 & out_rdy;
    assign out_vld = vld_p2;

    // ---- stage p1: capture the accepted beat ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            inj_armed <= 1'b0;
        end else if (accept) begin
            vld_p1    <= 1'b1;
            inj_armed <= 1'b0;
        end else begin
            if (load_p2) vld_p1 <= 1'b0;
            if (inj_req) inj_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_p1   <= data_in;
            parity_p1 <= parity_in;
            byp_p1    <= bypass;
            // A request in the accept cycle itself arms this beat.
            inj_p1    <= inj_armed | inj_req;
        end
    end

    // ---- decode and lockstep compare, combinational from p1 ----
    always_comb begin
        dec_a    = secded_decode(data_p1, parity_p1, 1'b0, byp_p1);
        dec_b    = secded_decode(data_p1, parity_p1, inj_p1, byp_p1);
        fault_p1 = ({dec_a.sbit, dec_a.dbit, dec_a.mask} !=
                    {dec_b.sbit, dec_b.dbit, dec_b.mask}) & ecc_fault_detc_en;
        corr_p1  = fault_p1 ? data_p1 : (data_p1 ^ dec_a.mask);
    end

    // ---- stage p2: output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2    <= 1'b0;
            data_out  <= '0;
            sbit_err  <= 1'b0;
            dbit_err  <= 1'b0;
            ecc_fault <= 1'b0;
        end else if (load_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_out  <= corr_p1;
                sbit_err  <= dec_a.sbit;
                dbit_err  <= dec_a.dbit;
                ecc_fault <= fault_p1;
            end
        end
    end

    // ---- counters and irq, updated on output take ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbit_cnt  <= '0;
            dbit_cnt  <= '0;
            fault_cnt <= '0;
            fault_irq <= 1'b0;
        end else if (cnt_clr) begin
            sbit_cnt  <= '0;
            dbit_cnt  <= '0;
            fault_cnt <= '0;
            fault_irq <= 1'b0;
        end else begin
            if (take_p2 && sbit_err)  sbit_cnt  <= sat_inc(sbit_cnt);
            if (take_p2 && dbit_err)  dbit_cnt  <= sat_inc(dbit_cnt);
            if (take_p2 && ecc_fault) fault_cnt <= sat_inc(fault_cnt);
            fault_irq <= (fault_thresh != '0) && (fault_cnt >= fault_thresh);
        end
    end

endmodule
